// File: rtl/dmi_pkg.sv
// Shared DMI definitions: request/response op encodings, DM register
// addresses and the master's state encoding.
package dmi_pkg;

  typedef enum logic [1:0] {
    DMI_OP_NOP      = 2'd0,
    DMI_OP_READ     = 2'd1,
    DMI_OP_WRITE    = 2'd2,
    DMI_OP_RESERVED = 2'd3
  } dmi_req_op_e;

  typedef enum logic [1:0] {
    DMI_RSP_SUCCESS = 2'd0,
    DMI_RSP_FAILED  = 2'd2
  } dmi_rsp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS     = 2'd1,
    ST_RECOVER = 2'd2,
    ST_RESP    = 2'd3
  } dmi_state_e;

  localparam logic [6:0] DM_ADDR_DATA0     = 7'h04;
  localparam logic [6:0] DM_ADDR_DATA1     = 7'h05;
  localparam logic [6:0] DM_ADDR_DMCONTROL = 7'h10;

endpackage

// File: rtl/wb_ack_timer.sv
// Ack timeout counter: cleared on load, advances while counting, and flags
// expiry on the cycle that would make it the LIMIT-th counted cycle.
module wb_ack_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = count_i && (cnt_q == LAST);

endmodule

// File: rtl/wishbone_dmi_master.sv
// DMI-to-Wishbone initiator: one single Wishbone cycle per DMI request, one response back.
// Optional ack timeout enabled by defining WISHBONE_DMI_MASTER_TIMEOUT_EN.
module wishbone_dmi_master
  import dmi_pkg::*;
#(
  parameter int ADDR_W         = 7,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [1:0]        rsp_op_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [31:0]       addr_o,
  output logic              we_o,
  output logic [DATA_W-1:0] data_o,
  output logic              cyc_o,
  output logic              stb_o,
  input  logic              ack_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              busy_o
);

  dmi_state_e        state_q;
  logic              reqReady_q;
  logic              rspValid_q;
  logic [1:0]        rspOp_q;
  logic [DATA_W-1:0] rspData_q;
  logic [31:0]       addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              cyc_q;
  logic              busy_q;
  logic              timeout;

`ifdef WISHBONE_DMI_MASTER_TIMEOUT_EN
  logic timerLoad;
  logic timerCount;

  assign timerLoad  = (state_q == ST_IDLE) && req_valid_i &&
                      ((req_op_i == DMI_OP_READ) || (req_op_i == DMI_OP_WRITE));
  assign timerCount = (state_q == ST_BUS) && !ack_i;

  wb_ack_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (timerLoad),
    .count_i  (timerCount),
    .expired_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // RECOVER waits for ack to fall so the slave is idle before any new cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      reqReady_q <= 1'b1;
      rspValid_q <= 1'b0;
      rspOp_q    <= DMI_RSP_SUCCESS;
      rspData_q  <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      cyc_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            reqReady_q <= 1'b0;
            busy_q     <= 1'b1;
            addr_q     <= {{(32-ADDR_W){1'b0}}, req_addr_i};
            wdata_q    <= req_data_i;
            we_q       <= (req_op_i == DMI_OP_WRITE);
            case (req_op_i)
              DMI_OP_READ, DMI_OP_WRITE: begin
                cyc_q   <= 1'b1;
                state_q <= ST_BUS;
              end
              DMI_OP_NOP: begin
                rspOp_q    <= DMI_RSP_SUCCESS;
                rspData_q  <= '0;
                rspValid_q <= 1'b1;
                state_q    <= ST_RESP;
              end
              default: begin
                rspOp_q    <= DMI_RSP_FAILED;
                rspData_q  <= '0;
                rspValid_q <= 1'b1;
                state_q    <= ST_RESP;
              end
            endcase
          end
        end
        ST_BUS: begin
          if (ack_i) begin
            rspData_q <= data_i;
            rspOp_q   <= DMI_RSP_SUCCESS;
            cyc_q     <= 1'b0;
            state_q   <= ST_RECOVER;
          end else if (timeout) begin
            rspData_q <= '0;
            rspOp_q   <= DMI_RSP_FAILED;
            cyc_q     <= 1'b0;
            state_q   <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          if (!ack_i) begin
            rspValid_q <= 1'b1;
            state_q    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rspValid_q <= 1'b0;
            reqReady_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = reqReady_q;
  assign rsp_valid_o = rspValid_q;
  assign rsp_op_o    = rspOp_q;
  assign rsp_data_o  = rspData_q;
  assign addr_o      = addr_q;
  assign we_o        = we_q;
  assign data_o      = wdata_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = cyc_q;
  assign busy_o      = busy_q;

endmodule
